// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending controller.
//   state_t : controller FSM states
//   prod_t  : product id carried from selection to dispense
//   COIN_*  : coin values in cents
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  typedef logic [1:0] prod_t;

  localparam int unsigned COIN_PENNY   = 1;
  localparam int unsigned COIN_NICKEL  = 5;
  localparam int unsigned COIN_DIME    = 10;
  localparam int unsigned COIN_QUARTER = 25;

endpackage

// File: rtl/change_dispenser.sv
// change_dispenser: greedy payout, one coin per cycle.
//   clk, rst_n      : clock, async active-low reset
//   start_i         : load amount_i and pay its first coin this cycle
//   amount_i        : amount to return (cents)
//   ret_*_o         : registered one-cycle coin pulses
//   rem_nxt_o       : remaining amount after this cycle's coin
//   done_o          : nothing left to pay
module change_dispenser
  import vend_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] amount_i,
  output logic         ret_quarter_o,
  output logic         ret_dime_o,
  output logic         ret_nickel_o,
  output logic         ret_penny_o,
  output logic [W-1:0] rem_nxt_o,
  output logic         done_o
);

  logic [W-1:0] rem_q, rem_d, cur, coin;
  logic [3:0]   ret_q, ret_d;   // {quarter, dime, nickel, penny}

  // On start the first coin comes straight from amount_i, so the first
  // pulse lands in the same cycle the controller enters CHANGE.
  always_comb begin
    cur   = start_i ? amount_i : rem_q;
    coin  = '0;
    ret_d = '0;
    if (cur != '0) begin
      if (cur >= W'(COIN_QUARTER)) begin
        coin = W'(COIN_QUARTER); ret_d = 4'b1000;
      end else if (cur >= W'(COIN_DIME)) begin
        coin = W'(COIN_DIME);    ret_d = 4'b0100;
      end else if (cur >= W'(COIN_NICKEL)) begin
        coin = W'(COIN_NICKEL);  ret_d = 4'b0010;
      end else begin
        coin = W'(COIN_PENNY);   ret_d = 4'b0001;
      end
    end
    rem_d = cur - coin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      ret_q <= '0;
    end else begin
      rem_q <= rem_d;
      ret_q <= ret_d;
    end
  end

  assign {ret_quarter_o, ret_dime_o, ret_nickel_o, ret_penny_o} = ret_q;
  assign rem_nxt_o = rem_d;
  assign done_o    = (rem_q == '0);

endmodule

// File: rtl/vend_controller.sv
// vend_controller: credit accumulation, selection/cancel arbitration,
// dispense strobe and change payout for a 4-product vending machine.
//   clk, reset               : clock, async active-low reset
//   penny/nickel/dime/quarter: one-cycle coin pulses from the sensor
//   select_valid, select     : product request
//   cancel                   : refund request
//   credit                   : current credit (cents)
//   busy                     : high in VEND or CHANGE
//   dispense, product        : one-cycle vend strobe and its product id
//   insufficient             : selection refused, credit below price
//   coin_reject              : coin not credited
//   ret_quarter..ret_penny   : one-cycle change pulses
// Optional: define VEND_TIMEOUT_EN to auto-cancel after TIMEOUT_CYCLES
// idle cycles in COLLECT.
module vend_controller
  import vend_pkg::*;
#(
  parameter int CREDIT_W       = 8,
  parameter int MAX_CREDIT     = 200,
  parameter int PRICE_0        = 65,
  parameter int PRICE_1        = 75,
  parameter int PRICE_2        = 100,
  parameter int PRICE_3        = 125,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                penny,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                select_valid,
  input  logic [1:0]          select,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                dispense,
  output logic [1:0]          product,
  output logic                insufficient,
  output logic                coin_reject,
  output logic                ret_quarter,
  output logic                ret_dime,
  output logic                ret_nickel,
  output logic                ret_penny
);

  // One extra bit so credit + coin never wraps before the ceiling check.
  localparam int SUM_W = CREDIT_W + 1;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  prod_t               product_q, product_d;
  logic                dispense_q, dispense_d;
  logic                insuff_q, insuff_d;
  logic                reject_q, reject_d;
  logic                busy_q, busy_d;

  logic                one_coin, any_coin, fits, accept, collecting;
  logic                cancel_eff, tmo_fire;
  logic [SUM_W-1:0]    coin_val, sum, price;
  logic                chg_start, chg_done;
  logic [CREDIT_W-1:0] chg_amount, chg_rem_nxt;

  function automatic logic [SUM_W-1:0] price_of(input prod_t id);
    case (id)
      2'd0:    price_of = SUM_W'(PRICE_0);
      2'd1:    price_of = SUM_W'(PRICE_1);
      2'd2:    price_of = SUM_W'(PRICE_2);
      default: price_of = SUM_W'(PRICE_3);
    endcase
  endfunction

  // Coin classification: only a single-coin cycle carries value.
  assign any_coin = |{quarter, dime, nickel, penny};
  assign one_coin = ($countones({quarter, dime, nickel, penny}) == 1);

  always_comb begin
    coin_val = '0;
    if (one_coin) begin
      if (quarter)     coin_val = SUM_W'(COIN_QUARTER);
      else if (dime)   coin_val = SUM_W'(COIN_DIME);
      else if (nickel) coin_val = SUM_W'(COIN_NICKEL);
      else             coin_val = SUM_W'(COIN_PENNY);
    end
  end

  assign collecting = (state_q == S_IDLE) || (state_q == S_COLLECT);
  assign fits       = ({1'b0, credit_q} + coin_val) <= SUM_W'(MAX_CREDIT);
  assign accept     = collecting && one_coin && fits;
  assign sum        = {1'b0, credit_q} + (accept ? coin_val : '0);
  assign price      = price_of(select);

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          activity;

  assign activity = any_coin || select_valid || cancel;
  assign tmo_fire = (state_q == S_COLLECT) && !activity &&
                    (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Counts consecutive quiet COLLECT cycles; cleared everywhere else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   tmo_q <= '0;
    else if (state_q == S_COLLECT && !activity && !tmo_fire) tmo_q <= tmo_q + 1'b1;
    else                                          tmo_q <= '0;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  assign cancel_eff = cancel || tmo_fire;

  // Payout starts either on a refund (credit includes a same-cycle coin)
  // or when a vend leaves change behind.
  assign chg_start  = (collecting && cancel_eff && (sum != '0)) ||
                      ((state_q == S_VEND) && (credit_q != '0));
  assign chg_amount = (state_q == S_VEND) ? credit_q : CREDIT_W'(sum);

  change_dispenser #(.W(CREDIT_W)) u_change (
    .clk           (clk),
    .rst_n         (reset),
    .start_i       (chg_start),
    .amount_i      (chg_amount),
    .ret_quarter_o (ret_quarter),
    .ret_dime_o    (ret_dime),
    .ret_nickel_o  (ret_nickel),
    .ret_penny_o   (ret_penny),
    .rem_nxt_o     (chg_rem_nxt),
    .done_o        (chg_done)
  );

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    product_d  = product_q;
    dispense_d = 1'b0;
    insuff_d   = 1'b0;
    reject_d   = any_coin && !accept;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        credit_d = CREDIT_W'(sum);
        state_d  = (sum != '0) ? S_COLLECT : S_IDLE;
        if (cancel_eff) begin
          // Cancel always blocks a same-cycle selection.
          if (sum != '0) begin
            state_d  = S_CHANGE;
            credit_d = chg_rem_nxt;
          end
        end else if (select_valid) begin
          if (sum >= price) begin
            state_d    = S_VEND;
            credit_d   = CREDIT_W'(sum - price);
            product_d  = select;
            dispense_d = 1'b1;
          end else begin
            insuff_d = 1'b1;
          end
        end
      end
      S_VEND: begin
        if (credit_q != '0) begin
          state_d  = S_CHANGE;
          credit_d = chg_rem_nxt;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        // Credit mirrors the dispenser's remaining amount; leave once the
        // last coin has been shown.
        if (chg_done) begin
          state_d  = S_IDLE;
          credit_d = '0;
        end else begin
          credit_d = chg_rem_nxt;
        end
      end
    endcase
    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      credit_q   <= '0;
      product_q  <= '0;
      dispense_q <= 1'b0;
      insuff_q   <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      product_q  <= product_d;
      dispense_q <= dispense_d;
      insuff_q   <= insuff_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
    end
  end

  assign credit       = credit_q;
  assign busy         = busy_q;
  assign dispense     = dispense_q;
  assign product      = product_q;
  assign insufficient = insuff_q;
  assign coin_reject  = reject_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed scoreboard bench for vend_controller.
// Each step drives one cycle of inputs and queues the output vector
// expected after that clock edge:
//   {credit[7:0], busy, dispense, product[1:0], insufficient, coin_reject,
//    ret_quarter, ret_dime, ret_nickel, ret_penny}
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       penny = 1'b0, nickel = 1'b0, dime = 1'b0, quarter = 1'b0;
  logic       select_valid = 1'b0;
  logic [1:0] select = 2'd0;
  logic       cancel = 1'b0;
  logic [7:0] credit;
  logic       busy, dispense, insufficient, coin_reject;
  logic [1:0] product;
  logic       ret_quarter, ret_dime, ret_nickel, ret_penny;

  typedef struct {
    string       tag;
    logic [17:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_pass = 0;
  int  n_chk  = 0;

  localparam logic [3:0] Q = 4'b1000, D = 4'b0100, N = 4'b0010, P = 4'b0001, Z = 4'b0000;

  vend_controller dut (
    .clk          (clk),
    .reset        (reset),
    .penny        (penny),
    .nickel       (nickel),
    .dime         (dime),
    .quarter      (quarter),
    .select_valid (select_valid),
    .select       (select),
    .cancel       (cancel),
    .credit       (credit),
    .busy         (busy),
    .dispense     (dispense),
    .product      (product),
    .insufficient (insufficient),
    .coin_reject  (coin_reject),
    .ret_quarter  (ret_quarter),
    .ret_dime     (ret_dime),
    .ret_nickel   (ret_nickel),
    .ret_penny    (ret_penny)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] e(input int cr, input bit bz, input bit ds,
                                    input int pr, input bit ins, input bit rj,
                                    input logic [3:0] rt);
    logic [7:0] c8;
    logic [1:0] p2;
    c8 = cr[7:0];
    p2 = pr[1:0];
    return {c8, bz, ds, p2, ins, rj, rt};
  endfunction

  function automatic logic [17:0] observed();
    return {credit, busy, dispense, product, insufficient, coin_reject,
            ret_quarter, ret_dime, ret_nickel, ret_penny};
  endfunction

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock of stimulus; expectation is queued before the edge and
  // popped once the registered outputs have settled.
  task automatic step(input string tag, input logic [3:0] c, input bit sv,
                      input logic [1:0] s, input bit cn, input logic [17:0] exp);
    sb_t item;
    {quarter, dime, nickel, penny} = c;
    select_valid = sv;
    select       = s;
    cancel       = cn;
    sb.push_back('{tag, exp});
    @(posedge clk);
    #1;
    {quarter, dime, nickel, penny} = 4'b0;
    select_valid = 1'b0;
    cancel       = 1'b0;
    if (sb.size() == 0) begin
      n_chk++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      item = sb.pop_front();
      chk(item.tag, observed(), item.exp);
    end
  endtask

  initial begin
    // reset state
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", observed(), e(0, 0, 0, 0, 0, 0, Z));
    reset = 1'b1;

    // cancel with zero credit is ignored
    step("cancel0", Z, 0, 2'd0, 1, e(0, 0, 0, 0, 0, 0, Z));

    // 75c, product 1: exact price, no change
    step("t1_q1", Q, 0, 2'd0, 0, e(25, 0, 0, 0, 0, 0, Z));
    step("t1_q2", Q, 0, 2'd0, 0, e(50, 0, 0, 0, 0, 0, Z));
    step("t1_q3", Q, 0, 2'd0, 0, e(75, 0, 0, 0, 0, 0, Z));
    step("t1_sel", Z, 1, 2'd1, 0, e(0, 1, 1, 1, 0, 0, Z));
    step("t1_idle", Z, 0, 2'd0, 0, e(0, 0, 0, 1, 0, 0, Z));

    // 65c, product 2 refused; top up to 115c, vend, 15c change
    step("t2_d", D, 0, 2'd0, 0, e(10, 0, 0, 1, 0, 0, Z));
    step("t2_n", N, 0, 2'd0, 0, e(15, 0, 0, 1, 0, 0, Z));
    step("t2_q1", Q, 0, 2'd0, 0, e(40, 0, 0, 1, 0, 0, Z));
    step("t2_q2", Q, 0, 2'd0, 0, e(65, 0, 0, 1, 0, 0, Z));
    step("t2_insuf", Z, 1, 2'd2, 0, e(65, 0, 0, 1, 1, 0, Z));
    step("t2_hold", Z, 0, 2'd0, 0, e(65, 0, 0, 1, 0, 0, Z));
    step("t2_q3", Q, 0, 2'd0, 0, e(90, 0, 0, 1, 0, 0, Z));
    step("t2_q4", Q, 0, 2'd0, 0, e(115, 0, 0, 1, 0, 0, Z));
    step("t2_sel", Z, 1, 2'd2, 0, e(15, 1, 1, 2, 0, 0, Z));
    step("t2_chg_d", Z, 0, 2'd0, 0, e(5, 1, 0, 2, 0, 0, D));
    step("t2_chg_n", Z, 0, 2'd0, 0, e(0, 1, 0, 2, 0, 0, N));
    step("t2_idle", Z, 0, 2'd0, 0, e(0, 0, 0, 2, 0, 0, Z));

    // 42c refund: one of each coin type plus an extra penny
    step("t3_q", Q, 0, 2'd0, 0, e(25, 0, 0, 2, 0, 0, Z));
    step("t3_d", D, 0, 2'd0, 0, e(35, 0, 0, 2, 0, 0, Z));
    step("t3_n", N, 0, 2'd0, 0, e(40, 0, 0, 2, 0, 0, Z));
    step("t3_p1", P, 0, 2'd0, 0, e(41, 0, 0, 2, 0, 0, Z));
    step("t3_p2", P, 0, 2'd0, 0, e(42, 0, 0, 2, 0, 0, Z));
    step("t3_cancel", Z, 0, 2'd0, 1, e(17, 1, 0, 2, 0, 0, Q));
    step("t3_ret_d", Z, 0, 2'd0, 0, e(7, 1, 0, 2, 0, 0, D));
    step("t3_ret_n", Z, 0, 2'd0, 0, e(2, 1, 0, 2, 0, 0, N));
    step("t3_ret_p1", Z, 0, 2'd0, 0, e(1, 1, 0, 2, 0, 0, P));
    step("t3_ret_p2", Z, 0, 2'd0, 0, e(0, 1, 0, 2, 0, 0, P));
    step("t3_idle", Z, 0, 2'd0, 0, e(0, 0, 0, 2, 0, 0, Z));

    // coin during CHANGE, then two coins at once
    step("t4_q1", Q, 0, 2'd0, 0, e(25, 0, 0, 2, 0, 0, Z));
    step("t4_q2", Q, 0, 2'd0, 0, e(50, 0, 0, 2, 0, 0, Z));
    step("t4_cancel", Z, 0, 2'd0, 1, e(25, 1, 0, 2, 0, 0, Q));
    step("t4_coin_chg", N, 0, 2'd0, 0, e(0, 1, 0, 2, 0, 1, Q));
    step("t4_idle", Z, 0, 2'd0, 0, e(0, 0, 0, 2, 0, 0, Z));
    step("t4_multi0", P | D, 0, 2'd0, 0, e(0, 0, 0, 2, 0, 1, Z));
    step("t4_n", N, 0, 2'd0, 0, e(5, 0, 0, 2, 0, 0, Z));
    step("t4_multi5", P | D, 0, 2'd0, 0, e(5, 0, 0, 2, 0, 1, Z));

    // fill to 190c, overflow reject, exact ceiling, cancel beats select
    for (int k = 1; k <= 7; k++)
      step("t5_fill", Q, 0, 2'd0, 0, e(5 + 25 * k, 0, 0, 2, 0, 0, Z));
    step("t5_d190", D, 0, 2'd0, 0, e(190, 0, 0, 2, 0, 0, Z));
    step("t5_ovf", Q, 0, 2'd0, 0, e(190, 0, 0, 2, 0, 1, Z));
    step("t5_d200", D, 0, 2'd0, 0, e(200, 0, 0, 2, 0, 0, Z));
    step("t5_cxl_sel", Z, 1, 2'd0, 1, e(175, 1, 0, 2, 0, 0, Q));
    for (int k = 1; k <= 7; k++)
      step("t5_pay", Z, 0, 2'd0, 0, e(175 - 25 * k, 1, 0, 2, 0, 0, Q));
    step("t5_idle", Z, 0, 2'd0, 0, e(0, 0, 0, 2, 0, 0, Z));

    // reset in the middle of a 55c refund (30c still owed)
    step("t6_q1", Q, 0, 2'd0, 0, e(25, 0, 0, 2, 0, 0, Z));
    step("t6_q2", Q, 0, 2'd0, 0, e(50, 0, 0, 2, 0, 0, Z));
    step("t6_n", N, 0, 2'd0, 0, e(55, 0, 0, 2, 0, 0, Z));
    step("t6_cancel", Z, 0, 2'd0, 1, e(30, 1, 0, 2, 0, 0, Q));
    #2 reset = 1'b0;
    #1;
    chk("t6_async_rst", observed(), e(0, 0, 0, 0, 0, 0, Z));
    reset = 1'b1;
    step("t6_after_n", N, 0, 2'd0, 0, e(5, 0, 0, 0, 0, 0, Z));
    step("t6_insuf0", Z, 1, 2'd0, 0, e(5, 0, 0, 0, 1, 0, Z));
    step("t6_cancel5", Z, 0, 2'd0, 1, e(0, 1, 0, 0, 0, 0, N));
    step("t6_idle", Z, 0, 2'd0, 0, e(0, 0, 0, 0, 0, 0, Z));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
